// File: rtl/rgb_pwm_driver_if.sv
// Duty-triple handshake bundle between a duty source (master) and the RGB PWM driver (slave).
// A transfer happens on a clock edge where duty_valid && duty_ready; the source may drop valid freely.
interface rgb_pwm_driver_if;
    logic [7:0] duty_r;
    logic [7:0] duty_g;
    logic [7:0] duty_b;
    logic       duty_valid;
    logic       duty_ready;

    modport master (
        output duty_r,
        output duty_g,
        output duty_b,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_r,
        input  duty_g,
        input  duty_b,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel 8-bit PWM LED driver with a prescaled 255-step period.
// New duty triples are double-buffered and applied only at period boundaries (or at once while disabled).
module rgb_pwm_driver #(
    parameter int unsigned PRESC_DIV = 47
) (
    input  logic              clki,
    input  logic              rst,
    input  logic              en,
    rgb_pwm_driver_if.slave   duty_if,
    output logic              rgb0,
    output logic              rgb1,
    output logic              rgb2,
    output logic              frame
);

    localparam int unsigned     PW         = (PRESC_DIV > 0) ? $clog2(PRESC_DIV + 1) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESC_DIV);
    localparam logic [7:0]      CNT_LAST   = 8'd254;

    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0][7:0] act_q, act_d;
    logic [2:0][7:0] pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic [2:0]      rgb_q, rgb_d;
    logic            frame_q, frame_d;

    logic tick;
    logic wrap;
    logic xfer;
    logic apply;

    assign duty_if.duty_ready = !pend_full_q && !rst;

    always_comb begin
        tick  = en && (presc_q == PRESC_LAST);
        wrap  = tick && (cnt_q == CNT_LAST);
        xfer  = duty_if.duty_valid && duty_if.duty_ready;
        // Pending duties land on a period boundary, or immediately when nothing is being displayed.
        apply = pend_full_q && (wrap || !en);

        presc_d     = presc_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        rgb_d       = '0;
        frame_d     = wrap;

        if (!en) begin
            presc_d = '0;
            cnt_d   = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
            end
        end

        if (apply) begin
            act_d       = pend_q;
            pend_full_d = 1'b0;
        end

        // xfer needs pend_full low and apply needs it high, so the two never collide.
        if (xfer) begin
            pend_d      = {duty_if.duty_b, duty_if.duty_g, duty_if.duty_r};
            pend_full_d = 1'b1;
        end

        for (int i = 0; i < 3; i++) begin
            rgb_d[i] = en && (cnt_q < act_q[i]);
        end
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            act_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            rgb_q       <= '0;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            rgb_q       <= rgb_d;
            frame_q     <= frame_d;
        end
    end

    assign rgb0  = rgb_q[0];
    assign rgb1  = rgb_q[1];
    assign rgb2  = rgb_q[2];
    assign frame = frame_q;

endmodule
